vball_pcm_fetch: RTL and testbench

PCM sample ROM fetch buffer between the `jt6295` ADPCM core's ROM port (`pcm_rom_addr`/`pcm_rom_data`/`pcm_rom_data_rdy`) and the SDRAM controller.

- Holds two 8-byte lines and serves byte reads from them.
- Issues 4-beat 16-bit bursts on a miss.
- Prefetches the sequentially next line, because ADPCM playback walks the ROM linearly.

---
 rtl/vball_pkg.sv | 13 +
 rtl/vball_pcm_line.sv | 49 ++++
 rtl/vball_pcm_fetch.sv | 150 +++++++++++++++
 tb/tb_vball_pcm_fetch.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vball_pkg.sv
// Shared definitions for the PCM ROM fetch buffer: refill state encoding and line geometry.
package vball_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL
  } fill_state_t;

  localparam int unsigned LINE_BYTES = 8;
  localparam int unsigned BEATS      = 4;

endpackage

// File: rtl/vball_pcm_line.sv
// One 8-byte PCM line buffer: tag, valid bit, 16-bit beat write port and byte read mux.
module vball_pcm_line
  import vball_pkg::*;
#(
  parameter int unsigned LINE_W = 15
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [1:0]        wr_beat,
  input  logic [15:0]       wr_data,
  input  logic              set_valid,
  input  logic [LINE_W-1:0] set_tag,
  input  logic [2:0]        rd_sel,
  output logic [7:0]        rd_byte,
  output logic [LINE_W-1:0] tag,
  output logic              valid
);

  logic [7:0] mem [LINE_BYTES];

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      valid <= 1'b0;
    end else if (set_valid) begin
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (set_valid) begin
      tag <= set_tag;
    end
  end

  // Little-endian beats: low byte lands on the even address.
  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      mem[{wr_beat, 1'b0}] <= wr_data[7:0];
      mem[{wr_beat, 1'b1}] <= wr_data[15:8];
    end
  end

  assign rd_byte = mem[rd_sel];

endmodule

// File: rtl/vball_pcm_fetch.sv
// Two-line PCM ROM fetch buffer between the ADPCM ROM port and SDRAM, with
// sequential next-line prefetch after every demand refill.
module vball_pcm_fetch
  import vball_pkg::*;
#(
  parameter logic [24:0] SD_BASE = 25'h0,
  parameter int unsigned LINE_W  = 15
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [LINE_W+2:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic              rom_data_rdy,
  output logic              sd_req,
  output logic [24:0]       sd_addr,
  input  logic              sd_ack,
  input  logic              sd_valid,
  input  logic [15:0]       sd_data
);

  fill_state_t       state, state_nx;
  logic [LINE_W+2:0] addr_q;
  logic              rdy_q;
  logic [7:0]        data_q;
  logic              lru;
  logic              pf_pend, pf_buf;
  logic [LINE_W-1:0] pf_line;
  logic [LINE_W-1:0] tgt_line;
  logic              tgt_buf, tgt_demand;
  logic [1:0]        beat;

  logic [1:0]        valid, hit, hold_q;
  logic [LINE_W-1:0] tag [2];
  logic [7:0]        rd_byte [2];

  logic [LINE_W-1:0] rom_line, addr_line_q, next_pf_line, next_line;
  logic              miss, beat_in, fill_done, start, dem_buf, next_buf, pf_resident;

  always_comb begin
    rom_line     = rom_addr[LINE_W+2:3];
    addr_line_q  = addr_q[LINE_W+2:3];
    for (int unsigned i = 0; i < 2; i++) begin
      hit[i]    = valid[i] && (tag[i] == rom_line);
      hold_q[i] = valid[i] && (tag[i] == addr_line_q);
    end
    miss         = ~|hold_q;
    beat_in      = (state == ST_FILL) && sd_valid;
    fill_done    = beat_in && (beat == 2'(BEATS - 1));
    start        = (state == ST_IDLE) && (state_nx == ST_REQ);
    dem_buf      = hold_q[0] ? 1'b1 : (hold_q[1] ? 1'b0 : lru);
    next_buf     = miss ? dem_buf : pf_buf;
    next_line    = miss ? addr_line_q : pf_line;
    next_pf_line = tgt_line + LINE_W'(1);
    pf_resident  = (valid[0] && (tag[0] == next_pf_line)) ||
                   (valid[1] && (tag[1] == next_pf_line));
  end

  vball_pcm_line #(.LINE_W(LINE_W)) u_b0 (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .clear     (start && !next_buf),
    .wr_en     (beat_in && !tgt_buf),
    .wr_beat   (beat),
    .wr_data   (sd_data),
    .set_valid (fill_done && !tgt_buf),
    .set_tag   (tgt_line),
    .rd_sel    (rom_addr[2:0]),
    .rd_byte   (rd_byte[0]),
    .tag       (tag[0]),
    .valid     (valid[0])
  );

  vball_pcm_line #(.LINE_W(LINE_W)) u_b1 (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .clear     (start && next_buf),
    .wr_en     (beat_in && tgt_buf),
    .wr_beat   (beat),
    .wr_data   (sd_data),
    .set_valid (fill_done && tgt_buf),
    .set_tag   (tgt_line),
    .rd_sel    (rom_addr[2:0]),
    .rd_byte   (rd_byte[1]),
    .tag       (tag[1]),
    .valid     (valid[1])
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A demand miss in IDLE takes priority over (and cancels) a pending prefetch;
  // a burst already past IDLE always runs to completion.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (miss || pf_pend) state_nx = ST_REQ;
      ST_REQ:  if (sd_ack)          state_nx = ST_FILL;
      ST_FILL: if (fill_done)       state_nx = ST_IDLE;
      default:                      state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    sd_req  = (state == ST_REQ);
    sd_addr = SD_BASE + 25'({tgt_line, 3'b000});
  end

  always_ff @(posedge clk_sys) begin
    addr_q <= rom_addr;
    if (!reset_n) begin
      rdy_q   <= 1'b0;
      data_q  <= '0;
      lru     <= 1'b0;
      pf_pend <= 1'b0;
      beat    <= '0;
    end else begin
      rdy_q <= |hit;
      if (|hit) begin
        data_q <= hit[0] ? rd_byte[0] : rd_byte[1];
        lru    <= hit[0];
      end
      if (start) begin
        tgt_line   <= next_line;
        tgt_buf    <= next_buf;
        tgt_demand <= miss;
        pf_pend    <= 1'b0;
      end
      if ((state == ST_REQ) && sd_ack) begin
        beat <= '0;
      end else if (beat_in) begin
        beat <= beat + 2'd1;
      end
      if (fill_done && tgt_demand) begin
        lru     <= ~tgt_buf;
        pf_line <= next_pf_line;
        pf_buf  <= ~tgt_buf;
        pf_pend <= !pf_resident;
      end
    end
  end

  assign rom_data     = data_q;
  assign rom_data_rdy = rdy_q && (rom_addr == addr_q);

endmodule

// File: tb/tb_vball_pcm_fetch.sv
// Directed bench for vball_pcm_fetch: cold miss, walk, address change, miss during
// prefetch, tag wrap and reset in the middle of a fill.
module tb_vball_pcm_fetch;

  localparam logic [24:0] BASE = 25'h0100000;

  localparam logic [63:0] L02   = 64'h7776_5554_3332_1110;
  localparam logic [63:0] L03   = 64'hFFFE_DDDC_BBBA_9998;
  localparam logic [63:0] L20   = 64'h0807_0605_0403_0201;
  localparam logic [63:0] L21   = 64'h1817_1615_1413_1211;
  localparam logic [63:0] L4000 = 64'hA7A6_A5A4_A3A2_A1A0;
  localparam logic [63:0] L4001 = 64'hB7B6_B5B4_B3B2_B1B0;
  localparam logic [63:0] L7FFF = 64'hC7C6_C5C4_C3C2_C1C0;
  localparam logic [63:0] LOLD  = 64'h4444_3333_2222_1111;
  localparam logic [63:0] LNEW  = 64'hE7E6_E5E4_E3E2_E1E0;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic [17:0] rom_addr = '0;
  logic [7:0]  rom_data;
  logic        rom_data_rdy;
  logic        sd_req;
  logic [24:0] sd_addr;
  logic        sd_ack   = 1'b0;
  logic        sd_valid = 1'b0;
  logic [15:0] sd_data  = '0;

  int errors = 0;
  int checks = 0;

  vball_pcm_fetch #(.SD_BASE(BASE), .LINE_W(15)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .rom_data_rdy (rom_data_rdy),
    .sd_req       (sd_req),
    .sd_addr      (sd_addr),
    .sd_ack       (sd_ack),
    .sd_valid     (sd_valid),
    .sd_data      (sd_data)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] line_byte(input logic [63:0] d, input logic [2:0] off);
    return d[8*off +: 8];
  endfunction

  task automatic wait_req(output int unsigned n);
    n = 0;
    while (!sd_req && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
  endtask

  task automatic ack_req();
    sd_ack = 1'b1;
    @(negedge clk_sys);
    sd_ack = 1'b0;
  endtask

  task automatic feed(input logic [63:0] d, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      sd_valid = 1'b1;
      sd_data  = d[16*k +: 16];
      @(negedge clk_sys);
    end
    sd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    rom_addr = 18'h00012;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (sd_req !== 1'b0) begin
      errors++; $display("FAIL reset_sd_req: got %b, want 0", sd_req);
    end
    checks++;
    if (rom_data_rdy !== 1'b0) begin
      errors++; $display("FAIL reset_rdy: got %b, want 0", rom_data_rdy);
    end
    checks++;
    if (rom_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h, want 00", rom_data);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    int unsigned n;
    wait_req(n);
    checks++;
    if (!sd_req || n != 1) begin
      errors++; $display("FAIL cold_req_latency: sd_req=%b after %0d cycles, want 1 after 1", sd_req, n);
    end
    checks++;
    if (sd_addr !== BASE + 25'h10) begin
      errors++; $display("FAIL cold_sd_addr: got %h, want %h", sd_addr, BASE + 25'h10);
    end
    ack_req();
    feed(L02, 0, 3);
    checks++;
    if (rom_data_rdy !== 1'b0) begin
      errors++; $display("FAIL cold_rdy_early: got %b on fill edge, want 0", rom_data_rdy);
    end
    @(negedge clk_sys);
    checks++;
    if (rom_data_rdy !== 1'b1 || rom_data !== 8'h32) begin
      errors++; $display("FAIL cold_data: rdy=%b data=%h, want rdy=1 data=32", rom_data_rdy, rom_data);
    end
    checks++;
    if (sd_req !== 1'b1 || sd_addr !== BASE + 25'h18) begin
      errors++; $display("FAIL cold_prefetch: sd_req=%b sd_addr=%h, want 1 %h", sd_req, sd_addr, BASE + 25'h18);
    end
    ack_req();
    feed(L03, 0, 3);
  endtask

  task automatic test_sequential_walk();
    logic [7:0] exp;
    for (int unsigned a = 18'h10; a <= 18'h1F; a++) begin
      rom_addr = 18'(a);
      exp = (a < 18'h18) ? line_byte(L02, 3'(a)) : line_byte(L03, 3'(a));
      @(negedge clk_sys);
      checks++;
      if (rom_data_rdy !== 1'b1 || rom_data !== exp || sd_req !== 1'b0) begin
        errors++;
        $display("FAIL walk_%h: rdy=%b data=%h sd_req=%b, want rdy=1 data=%h sd_req=0",
                 a, rom_data_rdy, rom_data, sd_req, exp);
      end
    end
  endtask

  task automatic test_addr_change();
    int unsigned n = 0;
    bit saw_rdy = 1'b0;
    rom_addr = 18'h00100;
    #1;
    checks++;
    if (rom_data_rdy !== 1'b0) begin
      errors++; $display("FAIL chg_same_cycle: rdy=%b, want 0", rom_data_rdy);
    end
    while (!sd_req && n < 20) begin
      @(negedge clk_sys);
      n++;
      if (rom_data_rdy !== 1'b0) saw_rdy = 1'b1;
    end
    checks++;
    if (saw_rdy) begin
      errors++; $display("FAIL chg_stale_rdy: rdy seen=1 before refill, want 0");
    end
    checks++;
    if (!sd_req || sd_addr !== BASE + 25'h100) begin
      errors++; $display("FAIL chg_req: sd_req=%b sd_addr=%h, want 1 %h", sd_req, sd_addr, BASE + 25'h100);
    end
    ack_req();
    feed(L20, 0, 3);
    @(negedge clk_sys);
    checks++;
    if (rom_data_rdy !== 1'b1 || rom_data !== 8'h01) begin
      errors++; $display("FAIL chg_data: rdy=%b data=%h, want 1 01", rom_data_rdy, rom_data);
    end
    checks++;
    if (sd_req !== 1'b1 || sd_addr !== BASE + 25'h108) begin
      errors++; $display("FAIL chg_prefetch: sd_req=%b sd_addr=%h, want 1 %h", sd_req, sd_addr, BASE + 25'h108);
    end
  endtask

  task automatic test_miss_during_prefetch();
    int unsigned n;
    ack_req();
    feed(L21, 0, 1);
    rom_addr = 18'h20000;
    feed(L21, 2, 3);
    checks++;
    if (sd_req !== 1'b0) begin
      errors++; $display("FAIL mdp_no_abort: sd_req=%b at prefetch completion, want 0", sd_req);
    end
    wait_req(n);
    checks++;
    if (!sd_req || n != 1 || sd_addr !== BASE + 25'h20000) begin
      errors++;
      $display("FAIL mdp_demand: sd_req=%b after %0d sd_addr=%h, want 1 after 1 %h",
               sd_req, n, sd_addr, BASE + 25'h20000);
    end
    ack_req();
    feed(L4000, 0, 3);
    @(negedge clk_sys);
    checks++;
    if (rom_data_rdy !== 1'b1 || rom_data !== 8'hA0) begin
      errors++; $display("FAIL mdp_data: rdy=%b data=%h, want 1 a0", rom_data_rdy, rom_data);
    end
    checks++;
    if (sd_req !== 1'b1 || sd_addr !== BASE + 25'h20008) begin
      errors++; $display("FAIL mdp_prefetch: sd_req=%b sd_addr=%h, want 1 %h", sd_req, sd_addr, BASE + 25'h20008);
    end
    ack_req();
    feed(L4001, 0, 3);
  endtask

  task automatic test_wrap();
    int unsigned n;
    rom_addr = 18'h3FFF8;
    wait_req(n);
    checks++;
    if (!sd_req || sd_addr !== BASE + 25'h3FFF8) begin
      errors++; $display("FAIL wrap_demand: sd_req=%b sd_addr=%h, want 1 %h", sd_req, sd_addr, BASE + 25'h3FFF8);
    end
    ack_req();
    feed(L7FFF, 0, 3);
    @(negedge clk_sys);
    checks++;
    if (rom_data_rdy !== 1'b1 || rom_data !== 8'hC0) begin
      errors++; $display("FAIL wrap_data: rdy=%b data=%h, want 1 c0", rom_data_rdy, rom_data);
    end
    checks++;
    if (sd_req !== 1'b1 || sd_addr !== BASE) begin
      errors++; $display("FAIL wrap_prefetch: sd_req=%b sd_addr=%h, want 1 %h", sd_req, sd_addr, BASE);
    end
  endtask

  task automatic test_reset_mid_fill();
    ack_req();
    feed(LOLD, 0, 1);
    reset_n  = 1'b0;
    rom_addr = 18'h00000;
    feed(LOLD, 2, 3);
    checks++;
    if (sd_req !== 1'b0 || rom_data_rdy !== 1'b0) begin
      errors++; $display("FAIL rst_fill_in_reset: sd_req=%b rdy=%b, want 0 0", sd_req, rom_data_rdy);
    end
    reset_n  = 1'b1;
    sd_valid = 1'b1;
    sd_data  = 16'h5A5A;
    @(negedge clk_sys);
    checks++;
    if (rom_data_rdy !== 1'b0) begin
      errors++; $display("FAIL rst_fill_rdy1: rdy=%b, want 0", rom_data_rdy);
    end
    @(negedge clk_sys);
    sd_valid = 1'b0;
    checks++;
    if (rom_data_rdy !== 1'b0 || sd_req !== 1'b1 || sd_addr !== BASE) begin
      errors++;
      $display("FAIL rst_fill_fresh: rdy=%b sd_req=%b sd_addr=%h, want 0 1 %h", rom_data_rdy, sd_req, sd_addr, BASE);
    end
    ack_req();
    feed(LNEW, 0, 3);
    @(negedge clk_sys);
    checks++;
    if (rom_data_rdy !== 1'b1 || rom_data !== 8'hE0) begin
      errors++; $display("FAIL rst_fill_data: rdy=%b data=%h, want 1 e0", rom_data_rdy, rom_data);
    end
    checks++;
    if (sd_req !== 1'b1 || sd_addr !== BASE + 25'h8) begin
      errors++; $display("FAIL rst_fill_prefetch: sd_req=%b sd_addr=%h, want 1 %h", sd_req, sd_addr, BASE + 25'h8);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk_sys);
    test_reset();
    test_cold_miss();
    test_sequential_walk();
    test_addr_change();
    test_miss_during_prefetch();
    test_wrap();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
